// File: rtl/dram_delay_pkg.sv
// dram_delay_pkg: shared defaults and helpers for the distributed-RAM delay line.
package dram_delay_pkg;
  localparam int DEF_LANES = 2;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEPTH = 2 ** DEF_ADDR_WIDTH;
  function automatic int unsigned eff_delay(input int unsigned delay);
    return (delay == 0) ? 1 : delay;
  endfunction
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction
endpackage

// File: rtl/dram_delay_lane.sv
// dram_delay_lane: WIDTH x 2**ADDR_WIDTH distributed RAM, sync write, async read.
module dram_delay_lane #(
  parameter int WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);
  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/dram_delay_line.sv
// dram_delay_line: multi-lane programmable delay line with fill tracking and
// recirculate mode; one shared write pointer drives every lane's RAM.
module dram_delay_line
  import dram_delay_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0]  delay,
  input  logic                   loop_en,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   filled
);
  localparam int LW = LANES * WIDTH;
  logic [ADDR_WIDTH-1:0] wp_q, wp_d, fill_q, fill_d, d_q, d, ra;
  logic                  out_valid_q, out_valid_d, filled_q, filled_d, flush, we;
  logic [LW-1:0]         out_data_q, out_data_d, rd_data, wr_data;
  assign d       = ADDR_WIDTH'(eff_delay(32'(delay)));
  assign flush   = d != d_q;
  assign ra      = wp_q - d;
  assign wr_data = loop_en ? rd_data : in_data;
  assign we      = in_valid & rst_n;
  always_comb begin
    filled_d    = !flush && fill_q >= d;
    wp_d        = in_valid ? wp_q + 1'b1 : wp_q;
    fill_d      = flush ? '0 : (in_valid && !loop_en && fill_q < d) ? fill_q + 1'b1 : fill_q;
    out_valid_d = in_valid && (loop_en ? filled_q : filled_d);
    out_data_d  = in_valid ? rd_data : out_data_q;
  end
  // d_q resets to the effective value of delay=0 so a first-cycle change flushes harmlessly
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q        <= '0;
      fill_q      <= '0;
      d_q         <= ADDR_WIDTH'(1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      filled_q    <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      fill_q      <= fill_d;
      d_q         <= d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      filled_q    <= filled_d;
    end
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    dram_delay_lane #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .clk  (clk),
      .we   (we),
      .waddr(wp_q),
      .wdata(wr_data[lane_lsb(g, WIDTH) +: WIDTH]),
      .raddr(ra),
      .rdata(rd_data[lane_lsb(g, WIDTH) +: WIDTH])
    );
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign filled    = filled_q;
endmodule

// File: tb/tb_dram_delay_line.sv
// tb_dram_delay_line: directed and random stimulus against a sample-level reference model.
module tb_dram_delay_line;
  localparam int LANES = 2, WIDTH = 8, AW = 5, DEPTH = 32, LW = 16;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, loop_en = 1'b0;
  logic [LW-1:0] in_data = '0;
  logic [AW-1:0] delay = '0;
  logic out_valid, filled;
  logic [LW-1:0] out_data;
  int errors = 0, checks = 0;
  logic [LW-1:0] mem [DEPTH];
  bit known [DEPTH];
  int wp, fill, dq;
  bit m_ov, m_filled, m_odk;
  logic [LW-1:0] m_od;
  logic [LW-1:0] pat [4];

  dram_delay_line #(.LANES(LANES), .WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .delay(delay),
    .loop_en(loop_en), .out_valid(out_valid), .out_data(out_data), .filled(filled)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    wp = 0; fill = 0; dq = 1; m_ov = 0; m_filled = 0; m_od = '0; m_odk = 1;
  endtask

  task automatic model_edge();
    int d, ra;
    bit flush, fnew, rk;
    logic [LW-1:0] rd;
    d = (delay == 0) ? 1 : int'(delay);
    flush = d != dq;
    ra = (wp - d + DEPTH) % DEPTH;
    fnew = !flush && fill >= d;
    rd = mem[ra];
    rk = known[ra];
    if (in_valid) begin
      m_ov = loop_en ? m_filled : fnew;
      m_od = rd;
      m_odk = rk;
      mem[wp] = loop_en ? rd : in_data;
      known[wp] = loop_en ? rk : 1'b1;
      wp = (wp + 1) % DEPTH;
      if (!loop_en && fill < d) fill++;
    end else m_ov = 0;
    if (flush) fill = 0;
    m_filled = fnew;
    dq = d;
  endtask

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [LW-1:0] din);
    in_valid = v;
    in_data = din;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("out_valid", {15'b0, out_valid}, {15'b0, m_ov});
    check("filled", {15'b0, filled}, {15'b0, m_filled});
    if (m_odk) check("out_data", out_data, m_od);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 0;
    model_reset();
    delay = 5'd3;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {15'b0, out_valid}, 16'h0);
    check("rst_out_data", out_data, 16'h0);
    check("rst_filled", {15'b0, filled}, 16'h0);
    rst_n = 1'b1;
    step(0, '0);
    for (int k = 1; k <= 8; k++) begin
      step(1, LW'(k));
      if (k == 4) begin
        check("first_valid", {15'b0, out_valid}, 16'h1);
        check("first_data", out_data, 16'h1);
        check("first_filled", {15'b0, filled}, 16'h1);
      end
    end
    delay = 5'd0;
    step(0, '0);
    step(1, 16'hA5A5);
    step(1, 16'h5A5A);
    check("d0_data", out_data, 16'hA5A5);
    check("d0_valid", {15'b0, out_valid}, 16'h1);
    delay = 5'd31;
    step(0, '0);
    for (int i = 0; i < 40; i++) step(1, LW'($urandom));
    delay = 5'd2;
    step(0, '0);
    for (int i = 0; i < 16; i++) step(i % 2 == 0, LW'($urandom));
    delay = 5'd4;
    step(0, '0);
    pat[0] = 16'h0A0A; pat[1] = 16'h1414; pat[2] = 16'h1E1E; pat[3] = 16'h2828;
    for (int i = 0; i < 4; i++) step(1, pat[i]);
    loop_en = 1'b1;
    for (int j = 0; j < 12; j++) begin
      step(1, LW'($urandom));
      check("loop_data", out_data, pat[j % 4]);
    end
    loop_en = 1'b0;
    step(0, '0);
    for (int i = 0; i < 8; i++) step(1, LW'($urandom));
    delay = 5'd2;
    for (int i = 0; i < 8; i++) step(1, LW'($urandom));
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", {15'b0, out_valid}, 16'h0);
    check("async_out_data", out_data, 16'h0);
    check("async_filled", {15'b0, filled}, 16'h0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) delay = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 14) == 0) loop_en = ~loop_en;
      step($urandom_range(0, 3) != 0, LW'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dram_delay_line.md
Name: dram_delay_line

Overview:
- Parametrised, multi-lane programmable delay line built on LUT distributed RAM, one circular buffer per lane.
- Successor to the fixed single-bit RAM shifter: adds configurable lane count and width, a runtime-programmable delay, valid qualification, fill tracking and a recirculate (loop) mode.
- Sits between switch/IO capture logic and LED/output logic in hardware tests. Intended to map onto RAM32M/RAM64M primitives.

Parameters:
- LANES, 2, number of independent data lanes sharing one address pointer
- WIDTH, 8, bits per lane
- ADDR_WIDTH, 5, buffer depth is 2**ADDR_WIDTH entries (5 gives 32, matching a RAM32M column)

Ports:
- clk  in  1  single clock, all logic is rising-edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample strobe; the buffer advances only on cycles where it is high
- in_data  in  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
- delay  in  ADDR_WIDTH  requested delay in samples; legal range 1..2**ADDR_WIDTH-1; 0 is treated as 1
- loop_en  in  1  0 = delay mode, 1 = recirculate mode
- out_valid  out  1  registered; delayed sample valid
- out_data  out  LANES*WIDTH  registered delayed data
- filled  out  1  high once the buffer holds at least delay samples since the last flush

Behaviour:
- Reset (async assert, sync release):
  - wp=0, fill=0, out_valid=0, out_data=0, filled=0.
  - RAM contents are not reset; they are undefined until written.
- Effective delay: d = (delay==0) ? 1 : delay. d is sampled every cycle.
- Read address: ra = (wp - d) mod 2**ADDR_WIDTH. Read is asynchronous from the distributed RAM; the output is registered.
- Delay mode (loop_en=0), on a cycle with in_valid=1:
  - ram[wp] <= in_data
  - out_data <= ram[ra] (value before this cycle's write)
  - wp <= wp+1, wrapping from 2**ADDR_WIDTH-1 to 0
  - fill <= min(fill+1, d)
  - out_valid <= 1 if fill >= d, else 0
- Cycles with in_valid=0: out_valid <= 0; out_data, wp and fill hold.
- Latency: the sample presented on valid strobe k appears on out_data one clock after valid strobe k+d, with out_valid high in that cycle.
- The first d strobes after reset or flush produce out_valid=0. Strobe d+1 produces the first out_valid=1.
- filled = (fill >= d), registered.
- Delay change: when the sampled d differs from its previous registered value, fill <= 0 (flush) in that cycle. This takes priority over a same-cycle in_valid increment, but the write and wp advance still occur. out_valid for that strobe is 0.
- Loop mode (loop_en=1), on a cycle with in_valid=1:
  - ram[wp] <= ram[ra] (recirculate); in_data is ignored
  - out_data <= ram[ra]
  - wp advances; fill holds
  - out_valid <= filled
- Effect of loop mode: the last d samples replay with period d indefinitely.
- Entering loop mode with filled=0 is allowed: out_valid stays 0 and the replayed data is undefined.
- Toggling loop_en does not flush.
- Width rules: all pointer arithmetic is ADDR_WIDTH-bit modulo. fill is ADDR_WIDTH bits and saturates at d.
- Reset mid-operation: all state clears immediately, out_valid drops asynchronously, and no write occurs in the reset cycle.

Decomposition:
- Shared package dram_delay_pkg:
  - function eff_delay(delay)
  - localparam DEPTH = 2**ADDR_WIDTH
  - lane slice helper
- One sub-module: dram_delay_lane, a WIDTH x DEPTH distributed RAM with synchronous write and asynchronous read, instantiated LANES times via generate.
- Pointer, fill and control logic live in the top module, shared by all lanes.

Test Plan:
- Reset, then delay=3, in_valid every cycle, in_data=1,2,3,... → out_valid first high one clock after strobe 4, carrying 1, then 2, 3, ...; filled rises with that first out_valid.
- delay=0 → behaves as delay=1; input 0xA5,0x5A → out 0xA5 one clock after the 0x5A strobe.
- delay=31 (max, ADDR_WIDTH=5), 40 samples → out_data = sample n-31; wp wraps past 31 with no gap in out_valid.
- in_valid gated every other cycle, delay=2 → output order preserved; out_valid high only one clock after valid strobes; data holds between them.
- Fill with 10,20,30,40, delay=4, then loop_en=1 for 12 strobes → output 10,20,30,40 repeated 3 times, in_data ignored.
- Change delay 4→2 mid-stream → out_valid low for the next 2 strobes, then samples delayed by 2; assert rst_n low mid-stream → out_valid and out_data become 0 asynchronously.
